// File: rtl/cam_pkg.sv
// Shared constants and helper functions for the CAM input-path deserializer.
package cam_pkg;

   // Bit-order selectors for the MSB_FIRST parameter.
   localparam int ORDER_LSB = 0;
   localparam int ORDER_MSB = 1;

   // Number of beats that make up one full word.
   function automatic int beats_f(input int word_w, input int lanes);
      return (lanes > 0) ? (word_w / lanes) : 1;
   endfunction

   // Width of a counter able to hold 0..BEATS inclusive.
   function automatic int cnt_w_f(input int word_w, input int lanes);
      return $clog2(beats_f(word_w, lanes) + 1);
   endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// Valid/ready holding register for a completed word plus its beat count.
// The upstream side may only load while in_ready is high.
module sipo_out_reg #(
   parameter int PAYLOAD_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 load,
   input  logic [PAYLOAD_W-1:0] load_data,
   input  logic                 out_ready,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [PAYLOAD_W-1:0] out_payload
);

   logic                 valid_q, valid_d;
   logic [PAYLOAD_W-1:0] payload_q, payload_d;

   // Room for a new word when nothing is pending or the pending word leaves now.
   assign in_ready    = !valid_q || out_ready;
   assign out_valid   = valid_q;
   assign out_payload = payload_q;

   // Next-state: clear wins, then a new word, then consumption of the held word.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
      valid_d   = valid_q;
      payload_d = payload_q;
      if (clr) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d   = 1'b1;
         payload_d = load_data;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
      end else begin
         // NOTE: sequential state is updated with non-blocking assignments so all registers sample the same pre-edge values.
         valid_q   <= valid_d;
         payload_q <= payload_d;
      end
   end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer: packs LANES-bit beats into a WORD_W-bit
// word in either bit order, supports short words via in_last, and presents
// completed words through a valid/ready holding register.
module sipo_deserializer
   import cam_pkg::*;
#(
   parameter int WORD_W    = 32,
   parameter int LANES     = 1,
   parameter int MSB_FIRST = ORDER_MSB
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               clr,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [LANES-1:0]                   in_data,
   input  logic                               in_last,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [WORD_W-1:0]                  out_data,
   output logic [cnt_w_f(WORD_W, LANES)-1:0]  out_beats
);

   localparam int BEATS = beats_f(WORD_W, LANES);
   localparam int CNT_W = cnt_w_f(WORD_W, LANES);

   // Refuse to build with a word that is not a whole number of beats.
   if (LANES < 1 || (WORD_W % LANES) != 0) begin : g_bad_cfg
      $error("sipo_deserializer: WORD_W must be a positive multiple of LANES");
   end

   logic [WORD_W-1:0] buf_q, buf_d, buf_upd;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              accept, complete;
   logic [WORD_W+CNT_W-1:0] out_payload;

   // A beat presented during clear is dropped.
   assign accept   = in_valid && in_ready && !clr;
   assign complete = accept && ((cnt_q == CNT_W'(BEATS - 1)) || in_last);

   // Buffer contents with the current beat merged into its lane slot.
   always_comb begin
      buf_upd = buf_q;
      for (int b = 0; b < BEATS; b++) begin
         if (cnt_q == CNT_W'(b)) begin
            if (MSB_FIRST == ORDER_MSB) begin
               buf_upd[WORD_W-1-b*LANES -: LANES] = in_data;
            end else begin
               buf_upd[b*LANES +: LANES] = in_data;
            end
         end
      end
   end

   // Assembly next-state: a completed word hands off and restarts from empty.
   always_comb begin
      buf_d = buf_q;
      cnt_d = cnt_q;
      if (clr || complete) begin
         buf_d = '0;
         cnt_d = '0;
      end else if (accept) begin
         buf_d = buf_upd;
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Assembly registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the assembly buffer is reset because short words rely on unwritten lanes reading zero.
         buf_q <= '0;
         cnt_q <= '0;
      end else begin
         buf_q <= buf_d;
         cnt_q <= cnt_d;
      end
   end

   sipo_out_reg #(
      .PAYLOAD_W (WORD_W + CNT_W)
   ) u_out_reg (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr),
      .load        (complete),
      .load_data   ({buf_upd, cnt_q + CNT_W'(1)}),
      .out_ready   (out_ready),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_payload (out_payload)
   );

   assign out_data  = out_payload[WORD_W+CNT_W-1:CNT_W];
   assign out_beats = out_payload[CNT_W-1:0];

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Parametrised serial-to-parallel deserializer for the CAM input path. It assembles a WORD_W-bit word from LANES-bit beats, with configurable bit order and early termination of short words. Completed words are presented on a valid/ready output register, so CAM key/search logic can apply backpressure.

Parameters:
WORD_W, 32, assembled word width in bits; must be a multiple of LANES.
LANES, 1, bits accepted per input beat (1 = pure serial).
MSB_FIRST, 1, 1: first beat lands in the most significant lane; 0: first beat lands in the least significant lane.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
clr  input  1  synchronous clear: discards partial word and pending output
in_valid  input  1  beat present
in_ready  output  1  beat accepted when in_valid && in_ready
in_data  input  LANES  beat payload
in_last  input  1  marks final beat of a (possibly short) word
out_valid  output  1  assembled word pending
out_ready  input  1  consumer accepts word
out_data  output  WORD_W  assembled word, zero-padded if short
out_beats  output  clog2(BEATS+1)  beats in out_data (BEATS = WORD_W/LANES)

Behaviour:
- Reset (rst=1, asynchronous) sets out_valid=0, out_data=0, out_beats=0, beat counter=0 and assembly buffer=0. This applies at any point, including mid-word.
- in_ready = !out_valid || out_ready. This is combinational from out_ready; there is no path from in_valid.
- Indexed write on accepted beat k (0-based):
  - MSB_FIRST=1: in_data goes to buf[WORD_W-1-k*LANES -: LANES].
  - MSB_FIRST=0: in_data goes to buf[k*LANES +: LANES].
- The word completes on an accepted beat when k==BEATS-1 or in_last=1.
- On completion, the next edge loads out_data with the buffer including the current beat. It sets out_beats=k+1 and out_valid=1, resets the beat counter to 0 and zeroes the buffer.
- Latency: out_valid rises 1 cycle after the completing beat is accepted.
- Back-to-back throughput is one beat per cycle while out_ready=1. A new word may complete in the same cycle the old one is consumed.
- out_valid && !out_ready: out_data and out_beats are held stable and in_ready=0. Assembly stalls and no beats are lost.
- out_valid falls on the edge where out_ready=1, unless a new word completes in that same cycle, in which case it stays 1 with the new data.
- in_last on beat 0 yields a 1-beat word; unwritten lanes read 0.
- in_last on beat BEATS-1 behaves identically to a normal full word.
- Beat counter wraps only via completion; it never exceeds BEATS-1.
- clr=1: next edge sets beat counter=0, buffer=0, out_valid=0. The beat presented in that cycle is dropped. clr has priority over everything except rst.
- Elaboration must fail (generate-time error) if WORD_W % LANES != 0 or LANES < 1.

Decomposition:
- Shared package cam_pkg holds the BEATS derivation, the CNT_W=$clog2(BEATS+1) constant function, and the bit-order localparams (ORDER_MSB/ORDER_LSB).
- One natural sub-module: sipo_out_reg, the valid/ready holding register that takes WORD_W+CNT_W payload and generates in_ready. The assembly buffer and counter remain in the top.

Test Plan:
1. WORD_W=8, LANES=1, MSB_FIRST=1: beats 1,0,1,1,0,0,1,0 with out_ready=1 -> out_data=8'hB2, out_beats=8, out_valid for 1 cycle, one cycle after the 8th beat.
2. Same stimulus, MSB_FIRST=0 -> out_data=8'h4D, out_beats=8.
3. WORD_W=8, LANES=1, MSB_FIRST=1: beats 1,1,1 with in_last on the 3rd -> out_data=8'hE0, out_beats=3. The next word starts at beat 0.
4. WORD_W=16, LANES=4, MSB_FIRST=1: beats 4'hA,4'hB,4'hC,4'hD back-to-back, twice, out_ready=1 -> two words 16'hABCD on consecutive 4-cycle boundaries with no bubble.
5. Backpressure: hold out_ready=0 after word 1 completes -> out_data stays 8'hB2, in_ready=0, driven beats are not consumed. Release out_ready -> word 1 is consumed, then word 2 assembles intact.
6. Reset/clear: after 5 beats, pulse rst asynchronously (mid-cycle) -> all outputs 0 immediately. Repeat with clr -> partial discarded, next full word 8'hB2 correct.
